// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM DAC.
//   - align_e / fmt_e : mode encodings latched at each period boundary
//   - PERIOD_EDGE / PERIOD_CENTER : period lengths for the default 10-bit counter
//   - to_duty() : sample -> duty conversion (sign flip, then truncate to counter width)
package pwm_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } align_e;

  typedef enum logic {
    OFFSET_BIN = 1'b0,
    TWOS_COMP  = 1'b1
  } fmt_e;

  localparam int DEFAULT_DW    = 10;
  localparam int DEFAULT_CW    = 10;
  localparam int PERIOD_EDGE   = 1 << DEFAULT_CW;
  localparam int PERIOD_CENTER = (1 << (DEFAULT_CW + 1)) - 2;

  // Two's complement becomes offset binary by inverting the MSB. The duty is
  // the top cw bits of the converted sample; the low bits are dropped, never
  // rounded, so full scale can never overflow the counter range.
  // The result is returned in 32 bits; callers size it to their counter width.
  function automatic logic [31:0] to_duty(input logic [31:0] sample,
                                          input fmt_e        fmt,
                                          input int          dw = DEFAULT_DW,
                                          input int          cw = DEFAULT_CW);
    logic [31:0] conv;
    conv = sample;
    if (fmt == TWOS_COMP) begin
      conv[dw-1] = ~conv[dw-1];
    end
    return conv >> (dw - cw);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a double-buffered duty value.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 0 forces the output low (shadow and pending are kept)
//   boundary   : first cycle of a period (counter 0, counting up, enabled)
//   wr         : write strobe; sample is converted and stored in the shadow
//   fmt        : latched sample format (0 offset binary, 1 two's complement)
//   sample     : raw channel sample
//   cnt        : shared period counter
//   pwm        : registered output, high while cnt < duty
//   pending    : shadow holds a value not yet copied to the active duty
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     boundary,
  input  logic                     wr,
  input  logic                     fmt,
  input  logic [DATA_WIDTH-1:0]    sample,
  input  logic [COUNTER_WIDTH-1:0] cnt,
  output logic                     pwm,
  output logic                     pending
);

  logic [COUNTER_WIDTH-1:0] shadow;
  logic [COUNTER_WIDTH-1:0] active;
  logic [COUNTER_WIDTH-1:0] wr_duty;
  logic [COUNTER_WIDTH-1:0] duty_eff;

  assign wr_duty = COUNTER_WIDTH'(to_duty(32'(sample), fmt_e'(fmt),
                                          DATA_WIDTH, COUNTER_WIDTH));

  // On a loading boundary the compare already uses the new duty, so the
  // first registered output of the period and the updated pulse line up.
  assign duty_eff = (boundary && pending) ? shadow : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (wr) begin
        shadow <= wr_duty;
      end
      // A write landing on the boundary goes to the shadow while the active
      // register takes the previous shadow; pending stays set for next period.
      if (boundary && pending) begin
        active <= shadow;
      end
      if (wr) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
      pwm <= enable && (cnt < duty_eff);
    end
  end

endmodule

// File: rtl/pwm_dac_mc.sv
// pwm_dac_mc: multi-channel PWM DAC with a shared period counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 0 holds the counter at 0 (up) and forces outputs low
//   signed_mode  : 1 = two's complement samples, 0 = offset binary
//   center_mode  : 1 = center-aligned up/down counting, 0 = edge-aligned
//   data_in      : packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_valid   : strobe writing data_in into every channel shadow
//   pwm_out      : registered PWM outputs
//   period_start : pulse on the first output cycle of each period
//   updated      : pulse when shadow values were copied to active duty
// Both mode inputs are only sampled at a period boundary; the latched format
// is the one applied to samples written during the period.
module pwm_dac_mc
  import pwm_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 10,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         signed_mode,
  input  logic                         center_mode,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic                         period_start,
  output logic                         updated
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     dir_down;
  align_e                   center_q;
  fmt_e                     signed_q;
  logic                     boundary;
  logic [NUM_CH-1:0]        pend;

  assign boundary = enable && (cnt == '0) && !dir_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      center_q     <= EDGE;
      signed_q     <= OFFSET_BIN;
      period_start <= 1'b0;
      updated      <= 1'b0;
    end else begin
      period_start <= boundary;
      updated      <= boundary && (|pend);
      if (boundary) begin
        center_q <= align_e'(center_mode);
        signed_q <= fmt_e'(signed_mode);
      end
      // The step out of count 0 is identical in both modes, so using the
      // latch value from before the boundary is safe.
      if (!enable) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (center_q == CENTER) begin
        if (!dir_down) begin
          if (cnt == CNT_MAX) begin
            cnt      <= CNT_MAX - CNT_ONE;
            dir_down <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end else begin
          // Turn around at 1 so count 0 appears once per center period.
          if (cnt == CNT_ONE) begin
            cnt      <= '0;
            dir_down <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      end else begin
        cnt      <= cnt + CNT_ONE;
        dir_down <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .boundary (boundary),
      .wr       (data_valid),
      .fmt      (signed_q),
      .sample   (data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .cnt      (cnt),
      .pwm      (pwm_out[k]),
      .pending  (pend[k])
    );
  end

endmodule

// File: tb/tb_pwm_dac_mc.sv
// tb_pwm_dac_mc: scenario tasks for pwm_dac_mc; per-period expectations are
// queued when stimulus is driven and popped when a period has been measured.
module tb_pwm_dac_mc;

  localparam int NCH    = 4;
  localparam int DW     = 10;
  localparam int P_EDGE = 1024;
  localparam int P_CTR  = 2046;
  localparam int BOUND  = 3000;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              signed_mode;
  logic              center_mode;
  logic [NCH*DW-1:0] data_in;
  logic              data_valid;
  logic [NCH-1:0]    pwm_out;
  logic              period_start;
  logic              updated;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  pwm_dac_mc #(.NUM_CH(NCH), .DATA_WIDTH(DW), .COUNTER_WIDTH(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .signed_mode  (signed_mode),
    .center_mode  (center_mode),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .updated      (updated)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // high cycles per period for a duty d (in counts)
  function automatic int exp_high(input int d, input bit ctr);
    if (!ctr) return d;
    if (d == 0) return 0;
    return 2 * d - 1;
  endfunction

  task automatic push_period(input int d0, input int d1, input int d2, input int d3,
                             input bit ctr, input int upd);
    exp_q.push_back(32'(exp_high(d0, ctr)));
    exp_q.push_back(32'(exp_high(d1, ctr)));
    exp_q.push_back(32'(exp_high(d2, ctr)));
    exp_q.push_back(32'(exp_high(d3, ctr)));
    exp_q.push_back(32'(ctr ? P_CTR : P_EDGE));
    exp_q.push_back(32'(upd));
  endtask

  task automatic write_samples(input int s0, input int s1, input int s2, input int s3);
    data_in    = {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_ps(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!period_start && cycles < BOUND);
    if (!period_start) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ps: no period_start within %0d cycles", BOUND);
    end
  endtask

  // Starts at a negedge where period_start is high; ends at the next one.
  task automatic measure(input string name);
    int hi[NCH];
    int len;
    int upd;
    logic [31:0] got[NCH+2];
    logic [31:0] e;
    len = 0;
    upd = 0;
    for (int k = 0; k < NCH; k++) hi[k] = 0;
    do begin
      for (int k = 0; k < NCH; k++) hi[k] += int'(pwm_out[k]);
      upd += int'(updated);
      len++;
      @(negedge clk);
    end while (!period_start && len < BOUND);
    for (int k = 0; k < NCH; k++) got[k] = 32'(hi[k]);
    got[NCH]   = 32'(len);
    got[NCH+1] = 32'(upd);
    for (int i = 0; i < NCH + 2; i++) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s[%0d]: got %0d, expected queue empty", name, i, got[i]);
      end else begin
        e = exp_q.pop_front();
        if (got[i] !== e) begin
          n_err++;
          $display("FAIL %s[%0d] (0-3 high cycles, 4 period, 5 updated): got %0d expected %0d",
                   name, i, got[i], e);
        end
      end
    end
  endtask

  task automatic measure_next(input string name);
    int c;
    wait_ps(c);
    measure(name);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    signed_mode = 1'b0;
    center_mode = 1'b0;
    data_in     = '0;
    data_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (pwm_out !== 4'b0)   begin n_err++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
    n_vec++; if (period_start !== 1'b0) begin n_err++; $display("FAIL reset_ps: got %b expected 0", period_start); end
    n_vec++; if (updated !== 1'b0)   begin n_err++; $display("FAIL reset_upd: got %b expected 0", updated); end
  endtask

  task automatic test_edge_offset();
    write_samples(512, 0, 1023, 300);
    push_period(512, 0, 1023, 300, 1'b0, 1);
    enable = 1'b1;
    measure_next("edge_offset");
  endtask

  task automatic test_signed();
    signed_mode = 1'b1;
    push_period(512, 0, 1023, 300, 1'b0, 0);
    measure("signed_latch");
    write_samples(10'h200, 10'h000, 10'h1FF, 10'h3FF);
    push_period(0, 512, 1023, 511, 1'b0, 1);
    measure_next("signed_conv");
  endtask

  task automatic test_center();
    signed_mode = 1'b0;
    center_mode = 1'b1;
    push_period(0, 512, 1023, 511, 1'b0, 0);
    measure("center_pre");
    write_samples(256, 0, 1023, 1);
    push_period(256, 0, 1023, 1, 1'b1, 1);
    measure_next("center_256");
  endtask

  task automatic test_double_buffer();
    center_mode = 1'b0;
    push_period(256, 0, 1023, 1, 1'b1, 0);
    measure("dbuf_pre");
    repeat (300) @(negedge clk);
    write_samples(100, 100, 100, 100);
    @(negedge clk);
    write_samples(700, 300, 1023, 5);
    push_period(700, 300, 1023, 5, 1'b0, 1);
    measure_next("dbuf_last_wins");
  endtask

  task automatic test_mode_change();
    int c;
    repeat (300) @(negedge clk);
    center_mode = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!period_start && c < BOUND);
    n_vec++;
    if (c !== 724) begin
      n_err++;
      $display("FAIL mode_change_remaining: got %0d cycles expected 724", c);
    end
    push_period(700, 300, 1023, 5, 1'b1, 0);
    measure("mode_change_center");
  endtask

  task automatic test_back_to_back();
    repeat (1000) @(negedge clk);
    write_samples(400, 401, 402, 403);
    repeat (1044) @(negedge clk);
    write_samples(800, 10, 0, 1022);     // lands on the boundary
    push_period(400, 401, 402, 403, 1'b1, 1);
    measure("coincide_prev");
    push_period(800, 10, 0, 1022, 1'b1, 1);
    measure("coincide_next");
  endtask

  task automatic test_reset_mid();
    repeat (600) @(negedge clk);
    n_vec++;
    if (pwm_out !== 4'b1001) begin
      n_err++;
      $display("FAIL pre_reset_pwm: got %b expected 1001", pwm_out);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (pwm_out !== 4'b0)      begin n_err++; $display("FAIL async_reset_pwm: got %b expected 0000", pwm_out); end
    n_vec++; if (period_start !== 1'b0) begin n_err++; $display("FAIL async_reset_ps: got %b expected 0", period_start); end
    n_vec++; if (updated !== 1'b0)      begin n_err++; $display("FAIL async_reset_upd: got %b expected 0", updated); end
    center_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (period_start !== 1'b1) begin n_err++; $display("FAIL post_reset_ps: got %b expected 1", period_start); end
    n_vec++; if (updated !== 1'b0)      begin n_err++; $display("FAIL post_reset_upd: got %b expected 0", updated); end
    push_period(0, 0, 0, 0, 1'b0, 0);
    measure("post_reset");
  endtask

  task automatic test_enable();
    int c;
    int bad;
    write_samples(50, 1000, 512, 1);
    push_period(50, 1000, 512, 1, 1'b0, 1);
    measure_next("enable_pre");
    write_samples(900, 900, 900, 900);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      n_vec++;
      if (pwm_out !== 4'b0 || period_start !== 1'b0) begin
        n_err++;
        bad++;
        if (bad <= 3)
          $display("FAIL disabled_low: cycle %0d got pwm %b ps %b expected 0000 0",
                   i, pwm_out, period_start);
      end
      @(negedge clk);
    end
    enable = 1'b1;
    wait_ps(c);
    n_vec++;
    if (c !== 1) begin
      n_err++;
      $display("FAIL reenable_latency: got %0d cycles expected 1", c);
    end
    push_period(900, 900, 900, 900, 1'b0, 1);
    measure("reenable_load");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_edge_offset();
    test_signed();
    test_center();
    test_double_buffer();
    test_mode_change();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
